// File: rtl/alu_datapath_pipe.sv
// rtl/alu_datapath_pipe.sv - 2-stage ALU datapath with 2^AW x WIDTH register file and load port
// Optional build macro DP_FORWARD_EN: bypass stage-2 result / ld_data into stage-1 operand capture.
module alu_datapath_pipe #(
    parameter int WIDTH = 32,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       alu,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic [AW-1:0]    addr3,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             res_valid
);
    localparam int NREG = 1 << AW;
    localparam int SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    logic [WIDTH-1:0] regs [NREG];

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [AW-1:0]    s1_dst;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // Stage 2 execute: operates purely on the stage-1 registers.
    always_comb begin
        sum      = '0;
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (s1_op)
            OP_ADD: begin
                sum      = {1'b0, s1_a} + {1'b0, s1_b};
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum      = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND: alu_res = s1_a & s1_b;
            OP_XOR: alu_res = s1_a ^ s1_b;
            OP_OR:  alu_res = s1_a | s1_b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SHL: alu_res = s1_a << s1_b[SW-1:0];
            OP_SHR: alu_res = s1_a >> s1_b[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    // Operand select at issue; the in-flight stage-2 result is the value being written this edge.
    always_comb begin
        op_a = regs[addr1];
        op_b = regs[addr2];
`ifdef DP_FORWARD_EN
        if (s1_valid && (s1_dst == addr1))
            op_a = alu_res;
        else if (ld_en && (ld_addr == addr1))
            op_a = ld_data;
        if (s1_valid && (s1_dst == addr2))
            op_b = alu_res;
        else if (ld_en && (ld_addr == addr2))
            op_b = ld_data;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_dst    <= '0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            s1_valid <= op_valid;
            if (op_valid) begin
                s1_op  <= alu;
                s1_a   <= op_a;
                s1_b   <= op_b;
                s1_dst <= addr3;
            end
            res_valid <= s1_valid;
            if (s1_valid) begin
                result <= alu_res;
                cout   <= alu_cout;
                zero   <= (alu_res == '0);
                ovf    <= alu_ovf;
            end
            // Writeback is ordered after the load so it wins on an address collision.
            if (ld_en)
                regs[ld_addr] <= ld_data;
            if (s1_valid)
                regs[s1_dst] <= alu_res;
        end
    end
endmodule

// File: tb/tb_alu_datapath_pipe.sv
// tb/tb_alu_datapath_pipe.sv - scoreboard bench for alu_datapath_pipe (default WIDTH=32, AW=2)
module tb_alu_datapath_pipe;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, XOR_ = 3'd3;
    localparam logic [2:0] OR_ = 3'd4, SLT = 3'd5, SHL = 3'd6, SHR = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  alu = '0;
    logic [1:0]  addr1 = '0, addr2 = '0, addr3 = '0;
    logic        ld_en = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] result;
    logic        cout, zero, ovf, res_valid;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    alu_datapath_pipe #(.WIDTH(32), .AW(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .alu(alu),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .result(result), .cout(cout), .zero(zero), .ovf(ovf), .res_valid(res_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ld(input logic [1:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [1:0] a1, input logic [1:0] a2,
                         input logic [1:0] a3, input logic [31:0] er, input logic ec,
                         input logic eo, input bit push);
        exp_t e;
        op_valid = 1'b1; alu = o; addr1 = a1; addr2 = a2; addr3 = a3;
        if (push) begin
            e.due = cyc + 2; e.res = er; e.c = ec; e.z = (er == 32'd0); e.o = eo;
            sb.push_back(e);
        end
        tick();
        op_valid = 1'b0;
    endtask

    // Results must appear exactly at the due cycle and nowhere else.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("res_valid", {31'd0, res_valid}, 32'd1);
                check("result", result, e.res);
                check("cout", {31'd0, cout}, {31'd0, e.c});
                check("zero", {31'd0, zero}, {31'd0, e.z});
                check("ovf", {31'd0, ovf}, {31'd0, e.o});
            end else begin
                check("res_valid_idle", {31'd0, res_valid}, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, cout, zero, ovf, res_valid}, 32'd0);
        mon_en = 1'b1;
        tick();

        ld(2'd1, 32'd5);
        ld(2'd2, 32'd3);
        do_op(ADD, 2'd1, 2'd2, 2'd0, 32'd8, 1'b0, 1'b0, 1'b1);
        idle(2);
        do_op(OR_, 2'd0, 2'd0, 2'd0, 32'd8, 1'b0, 1'b0, 1'b1);

        do_op(SUB, 2'd2, 2'd1, 2'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        do_op(SUB, 2'd1, 2'd2, 2'd3, 32'd2, 1'b1, 1'b0, 1'b1);

        ld(2'd1, 32'hFFFF_FFFF);
        ld(2'd2, 32'd1);
        do_op(ADD, 2'd1, 2'd2, 2'd3, 32'd0, 1'b1, 1'b0, 1'b1);
        ld(2'd1, 32'h7FFF_FFFF);
        do_op(ADD, 2'd1, 2'd2, 2'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b1);

        ld(2'd1, 32'd5);
        ld(2'd2, 32'd3);
        ld(2'd0, 32'd0);
        do_op(ADD, 2'd1, 2'd2, 2'd0, 32'd8, 1'b0, 1'b0, 1'b1);
`ifdef DP_FORWARD_EN
        do_op(XOR_, 2'd0, 2'd1, 2'd3, 32'd13, 1'b0, 1'b0, 1'b1);
        idle(2);
        do_op(OR_, 2'd3, 2'd3, 2'd3, 32'd13, 1'b0, 1'b0, 1'b1);
`else
        do_op(XOR_, 2'd0, 2'd1, 2'd3, 32'd5, 1'b0, 1'b0, 1'b1);
        idle(2);
        do_op(OR_, 2'd3, 2'd3, 2'd3, 32'd5, 1'b0, 1'b0, 1'b1);
`endif

        ld(2'd0, 32'd0);
        do_op(ADD, 2'd1, 2'd2, 2'd0, 32'd8, 1'b0, 1'b0, 1'b1);
        ld(2'd0, 32'h0000_DEAD);
        do_op(OR_, 2'd0, 2'd0, 2'd0, 32'd8, 1'b0, 1'b0, 1'b1);

        idle(2);
        do_op(ADD, 2'd1, 2'd2, 2'd3, 32'd8, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        for (int r = 0; r < 4; r++)
            do_op(OR_, 2'(r), 2'(r), 2'(r), 32'd0, 1'b0, 1'b0, 1'b1);

        ld(2'd1, 32'hF0F0_F0F0);
        ld(2'd2, 32'hFF00_FF00);
        do_op(AND_, 2'd1, 2'd2, 2'd3, 32'hF000_F000, 1'b0, 1'b0, 1'b1);
        ld(2'd1, 32'd1);
        ld(2'd2, 32'd31);
        do_op(SHL, 2'd1, 2'd2, 2'd3, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        ld(2'd2, 32'd33);
        do_op(SHL, 2'd1, 2'd2, 2'd3, 32'd2, 1'b0, 1'b0, 1'b1);
        ld(2'd1, 32'hFFFF_FFFF);
        ld(2'd2, 32'd1);
        do_op(SLT, 2'd1, 2'd2, 2'd3, 32'd1, 1'b0, 1'b0, 1'b1);
        do_op(SLT, 2'd2, 2'd1, 2'd3, 32'd0, 1'b0, 1'b0, 1'b1);
        ld(2'd1, 32'h8000_0000);
        ld(2'd2, 32'd4);
        do_op(SHR, 2'd1, 2'd2, 2'd3, 32'h0800_0000, 1'b0, 1'b0, 1'b1);

        idle(4);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
